// File: rtl/rnn_mem_arbiter.sv
// rnn_mem_arbiter: shares the single parameter/result SRAM port between the RNN core and a
// host loader. The host owns the port while the core is idle. The core owns it from its start
// handshake until one cycle after busy falls.
// Optional feature: define ARB_STATS_EN to add saturating run/beat/busy-cycle counters.
module rnn_mem_arbiter #(
  parameter int unsigned AW          = 17,
  parameter int unsigned DW          = 20,
  parameter logic [2:0]  CORE_WR_SEL = 3'b101,
  parameter bit          HOST_FIRST  = 1'b0,
  parameter int unsigned ARM_TIMEOUT = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ready_i,
  output logic          core_ready_o,
  input  logic          c_busy,
  input  logic          c_mce,
  input  logic [AW-1:0] c_maddr,
  input  logic [2:0]    c_msel,
  input  logic [DW-1:0] c_mdata_w,
  input  logic          h_valid,
  output logic          h_ready,
  input  logic          h_we,
  input  logic [AW-1:0] h_addr,
  input  logic [2:0]    h_sel,
  input  logic [DW-1:0] h_wdata,
  input  logic          h_lock,
  output logic          h_rvalid,
  output logic [DW-1:0] h_rdata,
  output logic          m_ce,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [2:0]    m_sel,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  output logic          core_done,
  output logic          err_timeout
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]   stat_runs,
  output logic [15:0]   stat_hbeats,
  output logic [31:0]   stat_busy
`endif
);

  localparam int unsigned CntW = (ARM_TIMEOUT > 1) ? $clog2(ARM_TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StHost,
    StCoreArm,
    StCoreRun,
    StCoreEnd
  } state_e;

  state_e state_q;

  logic [CntW-1:0] arm_cnt_q;

  // Host beat pipeline: issue stage and read-return stage.
  logic          iss_q;
  logic          iss_we_q;
  logic [AW-1:0] iss_addr_q;
  logic [2:0]    iss_sel_q;
  logic [DW-1:0] iss_wdata_q;
  logic          rvalid_q;
  logic [DW-1:0] rdata_q;

  logic host_pend;
  logic start_req;
  logic start;
  logic take_start;
  logic accept;
  logic core_sel;
  logic h_ready_c;
  logic core_ready_c;

  // Handshake decode: who may use the port this cycle.
  always_comb begin
    host_pend    = iss_q | rvalid_q;
    start_req    = ready_i & ~h_lock;
    start        = start_req & ~host_pend;
    h_ready_c    = 1'b0;
    core_ready_c = 1'b0;
    take_start   = 1'b0;
    core_sel     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start && !(h_valid && HOST_FIRST)) begin
          core_ready_c = 1'b1;
          take_start   = 1'b1;
        end else begin
          h_ready_c = 1'b1;
        end
      end
      StHost:    h_ready_c = HOST_FIRST ? 1'b1 : ~start_req;
      StCoreArm: begin
        core_ready_c = ready_i;
        core_sel     = 1'b1;
      end
      StCoreRun: core_sel = 1'b1;
      StCoreEnd: core_sel = 1'b1;
      default:   ;
    endcase
    // Hold both handshakes off while reset is asserted.
    h_ready      = h_ready_c & reset;
    core_ready_o = core_ready_c & reset;
    accept       = h_valid & h_ready;
  end

  // SRAM port mux: core passes straight through, host drives from its issue registers.
  always_comb begin
    if (core_sel) begin
      m_ce    = c_mce;
      m_we    = c_mce & (c_msel == CORE_WR_SEL);
      m_addr  = c_maddr;
      m_sel   = c_msel;
      m_wdata = c_mdata_w;
    end else begin
      m_ce    = iss_q;
      m_we    = iss_q & iss_we_q;
      m_addr  = iss_addr_q;
      m_sel   = iss_sel_q;
      m_wdata = iss_wdata_q;
    end
    h_rvalid = rvalid_q;
    // Read data is live from the SRAM on the return cycle, then held.
    h_rdata  = rvalid_q ? m_rdata : rdata_q;
  end

  assign core_done = (state_q == StCoreEnd);

  // Host beat pipeline registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      iss_q       <= 1'b0;
      iss_we_q    <= 1'b0;
      iss_addr_q  <= '0;
      iss_sel_q   <= '0;
      iss_wdata_q <= '0;
      rvalid_q    <= 1'b0;
      rdata_q     <= '0;
    end else begin
      iss_q    <= accept;
      rvalid_q <= iss_q & ~iss_we_q;
      if (accept) begin
        iss_we_q    <= h_we;
        iss_addr_q  <= h_addr;
        iss_sel_q   <= h_sel;
        iss_wdata_q <= h_wdata;
      end
      if (rvalid_q) begin
        rdata_q <= m_rdata;
      end
    end
  end

  // Ownership FSM with arm timeout and sticky error flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      arm_cnt_q   <= '0;
      err_timeout <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (take_start) begin
            state_q     <= StCoreArm;
            arm_cnt_q   <= '0;
            err_timeout <= 1'b0;
          end else if (accept) begin
            state_q <= StHost;
          end
        end
        StHost: begin
          if (!accept && !host_pend) begin
            state_q <= StIdle;
          end
        end
        StCoreArm: begin
          if (c_busy) begin
            state_q     <= StCoreRun;
            err_timeout <= 1'b0;
          end else if (arm_cnt_q == CntW'(ARM_TIMEOUT - 1)) begin
            state_q     <= StIdle;
            err_timeout <= 1'b1;
          end else begin
            arm_cnt_q <= arm_cnt_q + CntW'(1);
          end
        end
        StCoreRun: begin
          if (!c_busy) begin
            state_q <= StCoreEnd;
          end
        end
        StCoreEnd: state_q <= StIdle;
        default:   state_q <= StIdle;
      endcase
    end
  end

`ifdef ARB_STATS_EN
  // Saturating activity counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_runs   <= '0;
      stat_hbeats <= '0;
      stat_busy   <= '0;
    end else begin
      if (state_q == StCoreEnd && stat_runs != '1) begin
        stat_runs <= stat_runs + 16'd1;
      end
      if (accept && stat_hbeats != '1) begin
        stat_hbeats <= stat_hbeats + 16'd1;
      end
      if (state_q == StCoreRun && stat_busy != '1) begin
        stat_busy <= stat_busy + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_rnn_mem_arbiter.sv
// Self-checking bench for rnn_mem_arbiter. Instance a uses HOST_FIRST=0, instance b uses
// HOST_FIRST=1; both share stimulus and each has its own SRAM model.
module tb_rnn_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, ready_i, c_busy, c_mce;
  logic [16:0] c_maddr, h_addr;
  logic [2:0]  c_msel, h_sel;
  logic [19:0] c_mdata_w, h_wdata;
  logic        h_valid, h_we, h_lock;

  logic        core_ready_o, h_ready, h_rvalid, m_ce, m_we, core_done, err_timeout;
  logic [19:0] h_rdata, m_wdata, m_rdata;
  logic [16:0] m_addr;
  logic [2:0]  m_sel;

  logic        core_ready_b, h_ready_b, h_rvalid_b, m_ce_b, m_we_b, core_done_b, err_b;
  logic [19:0] h_rdata_b, m_wdata_b, m_rdata_b;
  logic [16:0] m_addr_b;
  logic [2:0]  m_sel_b;

`ifdef ARB_STATS_EN
  logic [15:0] st_runs, st_hb, st_runs_b, st_hb_b;
  logic [31:0] st_busy, st_busy_b;
`endif

  rnn_mem_arbiter #(.HOST_FIRST(1'b0)) dut_a (
    .clk(clk), .reset(reset), .ready_i(ready_i), .core_ready_o(core_ready_o),
    .c_busy(c_busy), .c_mce(c_mce), .c_maddr(c_maddr), .c_msel(c_msel),
    .c_mdata_w(c_mdata_w), .h_valid(h_valid), .h_ready(h_ready), .h_we(h_we),
    .h_addr(h_addr), .h_sel(h_sel), .h_wdata(h_wdata), .h_lock(h_lock),
    .h_rvalid(h_rvalid), .h_rdata(h_rdata), .m_ce(m_ce), .m_we(m_we), .m_addr(m_addr),
    .m_sel(m_sel), .m_wdata(m_wdata), .m_rdata(m_rdata), .core_done(core_done),
    .err_timeout(err_timeout)
`ifdef ARB_STATS_EN
    , .stat_runs(st_runs), .stat_hbeats(st_hb), .stat_busy(st_busy)
`endif
  );

  rnn_mem_arbiter #(.HOST_FIRST(1'b1)) dut_b (
    .clk(clk), .reset(reset), .ready_i(ready_i), .core_ready_o(core_ready_b),
    .c_busy(c_busy), .c_mce(c_mce), .c_maddr(c_maddr), .c_msel(c_msel),
    .c_mdata_w(c_mdata_w), .h_valid(h_valid), .h_ready(h_ready_b), .h_we(h_we),
    .h_addr(h_addr), .h_sel(h_sel), .h_wdata(h_wdata), .h_lock(h_lock),
    .h_rvalid(h_rvalid_b), .h_rdata(h_rdata_b), .m_ce(m_ce_b), .m_we(m_we_b),
    .m_addr(m_addr_b), .m_sel(m_sel_b), .m_wdata(m_wdata_b), .m_rdata(m_rdata_b),
    .core_done(core_done_b), .err_timeout(err_b)
`ifdef ARB_STATS_EN
    , .stat_runs(st_runs_b), .stat_hbeats(st_hb_b), .stat_busy(st_busy_b)
`endif
  );

  // Synchronous SRAM models, read data valid the cycle after a read enable.
  logic [19:0] mem_a [256];
  logic [19:0] mem_b [256];
  always @(posedge clk) begin
    if (m_ce) begin
      if (m_we) mem_a[m_addr[7:0]] <= m_wdata ^ {17'd0, m_sel} ^ {17'd0, m_sel};
      else      m_rdata <= mem_a[m_addr[7:0]];
    end
    if (m_ce_b) begin
      if (m_we_b) mem_b[m_addr_b[7:0]] <= m_wdata_b ^ {17'd0, m_sel_b} ^ {17'd0, m_sel_b};
      else        m_rdata_b <= mem_b[m_addr_b[7:0]];
    end
  end

  typedef struct {
    logic        mce;
    logic [16:0] addr;
    logic [2:0]  sel;
    logic [19:0] wd;
    logic        e_ce;
    logic        e_we;
    logic [16:0] e_addr;
    logic [2:0]  e_sel;
    logic [19:0] e_wd;
  } vec_t;

  vec_t tbl [8];
  int   n_cmp;
  int   n_err;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host_beat(input logic we, input logic [16:0] a, input logic [2:0] s,
                           input logic [19:0] d);
    h_valid = 1'b1;
    h_we    = we;
    h_addr  = a;
    h_sel   = s;
    h_wdata = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit seen_rv;
    bit got;
    n_cmp = 0;
    n_err = 0;
    tbl[0] = '{1'b1, 17'h00000, 3'b000, 20'h00000, 1'b1, 1'b0, 17'h00000, 3'b000, 20'h00000};
    tbl[1] = '{1'b1, 17'h1FFFF, 3'b101, 20'hFFFFF, 1'b1, 1'b1, 17'h1FFFF, 3'b101, 20'hFFFFF};
    tbl[2] = '{1'b0, 17'h0AAAA, 3'b101, 20'h55555, 1'b0, 1'b0, 17'h0AAAA, 3'b101, 20'h55555};
    tbl[3] = '{1'b1, 17'h15555, 3'b100, 20'hAAAAA, 1'b1, 1'b0, 17'h15555, 3'b100, 20'hAAAAA};
    tbl[4] = '{1'b1, 17'h00123, 3'b111, 20'h00001, 1'b1, 1'b0, 17'h00123, 3'b111, 20'h00001};
    tbl[5] = '{1'b1, 17'h10000, 3'b101, 20'h80000, 1'b1, 1'b1, 17'h10000, 3'b101, 20'h80000};
    tbl[6] = '{1'b0, 17'h00001, 3'b001, 20'h12345, 1'b0, 1'b0, 17'h00001, 3'b001, 20'h12345};
    tbl[7] = '{1'b1, 17'h0FFFF, 3'b001, 20'h7FFFF, 1'b1, 1'b0, 17'h0FFFF, 3'b001, 20'h7FFFF};

    reset = 1'b0; ready_i = 1'b0; c_busy = 1'b0; c_mce = 1'b0; c_maddr = '0; c_msel = '0;
    c_mdata_w = '0; h_we = 1'b0; h_addr = '0; h_sel = '0; h_wdata = '0; h_lock = 1'b0;
    h_valid = 1'b1;

    // Reset held 3 cycles with host valid: everything quiet.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_h_ready", {31'd0, h_ready}, 0);
    chk("rst_core_ready", {31'd0, core_ready_o}, 0);
    chk("rst_m_ce", {31'd0, m_ce}, 0);
    chk("rst_m_we", {31'd0, m_we}, 0);
    chk("rst_m_addr", {15'd0, m_addr}, 0);
    chk("rst_h_rvalid", {31'd0, h_rvalid}, 0);
    chk("rst_h_rdata", {12'd0, h_rdata}, 0);
    chk("rst_core_done", {31'd0, core_done}, 0);
    chk("rst_err", {31'd0, err_timeout}, 0);
    chk("rst_b_h_ready", {31'd0, h_ready_b}, 0);
    h_valid = 1'b0;
    reset   = 1'b1;
    #1;
    chk("rel_h_ready", {31'd0, h_ready}, 1);

    // Host write then read back.
    tick();
    host_beat(1'b1, 17'h00010, 3'b010, 20'h12345);
    #1 chk("wr_h_ready", {31'd0, h_ready}, 1);
    tick();
    h_valid = 1'b0;
    #1;
    chk("wr_m_ce", {31'd0, m_ce}, 1);
    chk("wr_m_we", {31'd0, m_we}, 1);
    chk("wr_m_addr", {15'd0, m_addr}, 32'h10);
    chk("wr_m_sel", {29'd0, m_sel}, 2);
    chk("wr_m_wdata", {12'd0, m_wdata}, 32'h12345);
    tick();
    host_beat(1'b0, 17'h00010, 3'b010, 20'h00000);
    #1 chk("rd_h_ready", {31'd0, h_ready}, 1);
    tick();
    h_valid = 1'b0;
    #1;
    chk("rd_m_ce", {31'd0, m_ce}, 1);
    chk("rd_m_we", {31'd0, m_we}, 0);
    chk("rd_m_addr", {15'd0, m_addr}, 32'h10);
    chk("rd_rvalid_early", {31'd0, h_rvalid}, 0);
    tick();
    #1;
    chk("rd_h_rvalid", {31'd0, h_rvalid}, 1);
    chk("rd_h_rdata", {12'd0, h_rdata}, 32'h12345);
    tick();
    #1;
    chk("rd_rvalid_pulse", {31'd0, h_rvalid}, 0);
    chk("rd_m_ce_off", {31'd0, m_ce}, 0);
    repeat (2) tick();

    // Core run: start in IDLE, busy for 100 cycles, table-driven pass-through checks.
    ready_i = 1'b1;
    #1;
    chk("run_core_ready", {31'd0, core_ready_o}, 1);
    chk("run_h_ready", {31'd0, h_ready}, 0);
    tick();
    ready_i = 1'b0;
    c_busy  = 1'b1;
    for (int i = 0; i < 100; i++) begin
      c_mce     = tbl[i % 8].mce;
      c_maddr   = tbl[i % 8].addr;
      c_msel    = tbl[i % 8].sel;
      c_mdata_w = tbl[i % 8].wd;
      #1;
      chk("mux_m_ce", {31'd0, m_ce}, {31'd0, tbl[i % 8].e_ce});
      chk("mux_m_we", {31'd0, m_we}, {31'd0, tbl[i % 8].e_we});
      chk("mux_m_addr", {15'd0, m_addr}, {15'd0, tbl[i % 8].e_addr});
      chk("mux_m_sel", {29'd0, m_sel}, {29'd0, tbl[i % 8].e_sel});
      chk("mux_m_wdata", {12'd0, m_wdata}, {12'd0, tbl[i % 8].e_wd});
      tick();
    end
    c_busy = 1'b0;
    #1 chk("end_done_early", {31'd0, core_done}, 0);
    tick();
    #1;
    chk("end_core_done", {31'd0, core_done}, 1);
    chk("end_m_addr", {15'd0, m_addr}, 32'h15555);
    chk("end_m_ce", {31'd0, m_ce}, 1);
    tick();
    #1;
    chk("idle_done_pulse", {31'd0, core_done}, 0);
    chk("idle_m_ce_ignores_core", {31'd0, m_ce}, 0);
    chk("idle_h_ready", {31'd0, h_ready}, 1);
    c_mce = 1'b0;

    // Host lock blocks starts.
    h_lock  = 1'b1;
    ready_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("lock_core_ready", {31'd0, core_ready_o}, 0);
      chk("lock_h_ready", {31'd0, h_ready}, 1);
      tick();
    end
    h_lock  = 1'b0;
    ready_i = 1'b0;

    // Start request arriving during a host beat: h_ready drops, start taken after drain.
    host_beat(1'b1, 17'h00020, 3'b001, 20'hABCDE);
    tick();
    h_valid = 1'b0;
    ready_i = 1'b1;
    #1;
    chk("pend_h_ready", {31'd0, h_ready}, 0);
    chk("pend_core_ready", {31'd0, core_ready_o}, 0);
    got = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      #1;
      if (core_ready_o) begin
        got = 1'b1;
        break;
      end
    end
    chk("pend_start_taken", {31'd0, got}, 1);
    tick();
    ready_i = 1'b0;
    c_busy  = 1'b1;
    tick();
    c_busy = 1'b0;
    repeat (3) tick();

    // Same-cycle tie: instance a gives the core the port, instance b serves the host first.
    ready_i = 1'b1;
    host_beat(1'b0, 17'h00010, 3'b010, 20'h00000);
    #1;
    chk("tie_core_ready", {31'd0, core_ready_o}, 1);
    chk("tie_h_ready", {31'd0, h_ready}, 0);
    chk("tie_b_core_ready", {31'd0, core_ready_b}, 0);
    chk("tie_b_h_ready", {31'd0, h_ready_b}, 1);
    tick();
    h_valid = 1'b0;
    #1;
    chk("tie_b_m_ce", {31'd0, m_ce_b}, 1);
    chk("tie_b_m_we", {31'd0, m_we_b}, 0);
    chk("tie_b_core_ready_hold", {31'd0, core_ready_b}, 0);
    seen_rv = 1'b0;
    got     = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      #1;
      if (core_ready_b) begin
        chk("tie_b_ready_after_rvalid", {31'd0, seen_rv}, 1);
        got = 1'b1;
        break;
      end
      if (h_rvalid_b) begin
        seen_rv = 1'b1;
        chk("tie_b_rdata", {12'd0, h_rdata_b}, 32'h12345);
      end
    end
    chk("tie_b_core_ready_seen", {31'd0, got}, 1);
    reset   = 1'b0;
    ready_i = 1'b0;
    tick();
    reset = 1'b1;
    tick();

    // Arm timeout: start pulse, busy never rises.
    ready_i = 1'b1;
    #1 chk("to_core_ready", {31'd0, core_ready_o}, 1);
    tick();
    ready_i = 1'b0;
    #1 chk("to_err_start", {31'd0, err_timeout}, 0);
    repeat (7) tick();
    #1;
    chk("to_err_early", {31'd0, err_timeout}, 0);
    chk("to_h_ready_arm", {31'd0, h_ready}, 0);
    tick();
    #1;
    chk("to_err", {31'd0, err_timeout}, 1);
    chk("to_h_ready_idle", {31'd0, h_ready}, 1);
    chk("to_core_ready_idle", {31'd0, core_ready_o}, 0);

    // Next accepted start clears the error; then an async reset mid-run.
    ready_i = 1'b1;
    #1 chk("clr_core_ready", {31'd0, core_ready_o}, 1);
    tick();
    ready_i = 1'b0;
    #1 chk("clr_err", {31'd0, err_timeout}, 0);
    c_busy = 1'b1;
    c_mce  = 1'b1;
    tick();
    #1 chk("ar_run_m_ce", {31'd0, m_ce}, 1);
    #2 reset = 1'b0;
    #1;
    chk("ar_m_ce", {31'd0, m_ce}, 0);
    chk("ar_h_ready", {31'd0, h_ready}, 0);
    chk("ar_core_done", {31'd0, core_done}, 0);
    tick();
    c_busy = 1'b0;
    c_mce  = 1'b0;
    reset  = 1'b1;
    #1;
    chk("ar_post_h_ready", {31'd0, h_ready}, 1);
    chk("ar_post_m_ce", {31'd0, m_ce}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
